// File: rtl/ifetch_req_pkg.sv
// Shared types and constants for the PC-generation / ibus request stage.
// Optional IFETCH_MISALIGN_CHECK_EN keeps misaligned redirect targets instead of aligning them.
package ifetch_req_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } ifetch_state_t;

    localparam logic [63:0] PC_RESET_DEF  = 64'h8000_0000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] raw_instr;
        logic [63:0] pc;
        logic        valid;
    } fetch_out_t;

    // Without the misalign check, targets are silently word-aligned on load.
    function automatic logic [63:0] load_pc(input logic [63:0] target);
`ifdef IFETCH_MISALIGN_CHECK_EN
        return target;
`else
        return {target[63:2], 2'b00};
`endif
    endfunction

endpackage

// File: rtl/ifetch_req.sv
// Fetch PC owner: one outstanding ibus request, redirect/stall handling, fetch handoff.
// IFETCH_MISALIGN_CHECK_EN adds instr_misalign and skips the bus for misaligned PCs.
module ifetch_req
    import ifetch_req_pkg::*;
#(
    parameter logic [63:0] PC_RESET  = PC_RESET_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic [63:0] pc,
    output logic [31:0] raw_instr,
    output logic        ivalid,
`ifdef IFETCH_MISALIGN_CHECK_EN
    output logic        instr_misalign,
`endif
    output logic        iwait
);

    ifetch_state_t state;
    logic [63:0]   pc_q;
    logic [63:0]   redir_q;
    logic          drop_q;
    fetch_out_t    out_q;
    logic          misaligned;

`ifdef IFETCH_MISALIGN_CHECK_EN
    logic misalign_q;
    assign misaligned     = (pc_q[1:0] != 2'b00);
    assign instr_misalign = misalign_q;
`else
    assign misaligned = 1'b0;
`endif

    // Address comes straight from pc_q, which only moves on data_ok or outside FETCH.
    assign ireq_valid = (state == FETCH) & ~misaligned & ~reset;
    assign ireq_addr  = pc_q;
    assign iwait      = ireq_valid & ~iresp_data_ok;

    assign pc        = out_q.pc;
    assign raw_instr = out_q.raw_instr;
    assign ivalid    = out_q.valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            pc_q    <= PC_RESET;
            redir_q <= PC_RESET;
            drop_q  <= 1'b0;
            out_q   <= '{raw_instr: NOP_INSTR, pc: 64'd0, valid: 1'b0};
`ifdef IFETCH_MISALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    if (misaligned) begin
                        // No bus traffic: present a NOP slot flagged as misaligned.
                        if (redirect_valid) begin
                            pc_q <= load_pc(redirect_pc);
                        end else begin
                            out_q <= '{raw_instr: NOP_INSTR, pc: pc_q, valid: 1'b1};
                            pc_q  <= pc_q + 64'd4;
                            state <= ISSUE;
`ifdef IFETCH_MISALIGN_CHECK_EN
                            misalign_q <= 1'b1;
`endif
                        end
                    end else if (iresp_data_ok) begin
                        if (drop_q || redirect_valid) begin
                            pc_q   <= redirect_valid ? load_pc(redirect_pc) : redir_q;
                            drop_q <= 1'b0;
                        end else begin
                            out_q <= '{raw_instr: iresp_data, pc: pc_q, valid: 1'b1};
                            pc_q  <= pc_q + 64'd4;
                            state <= ISSUE;
                        end
                    end else if (redirect_valid) begin
                        drop_q  <= 1'b1;
                        redir_q <= load_pc(redirect_pc);
                    end
                end
                ISSUE: begin
                    if (redirect_valid) begin
                        out_q.valid <= 1'b0;
                        pc_q        <= load_pc(redirect_pc);
                        state       <= FETCH;
`ifdef IFETCH_MISALIGN_CHECK_EN
                        misalign_q <= 1'b0;
`endif
                    end else if (!stall) begin
                        out_q.valid <= 1'b0;
                        state       <= FETCH;
`ifdef IFETCH_MISALIGN_CHECK_EN
                        misalign_q <= 1'b0;
`endif
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_req.sv
// Directed bench for ifetch_req: reset, fetch, stall, redirects, wrap, reset mid-transaction.
// Inputs change and outputs are sampled on the falling edge.
module tb_ifetch_req;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic [63:0] pc;
    logic [31:0] raw_instr;
    logic        ivalid;
    logic        iwait;
`ifdef IFETCH_MISALIGN_CHECK_EN
    logic        instr_misalign;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    ifetch_req dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .pc             (pc),
        .raw_instr      (raw_instr),
        .ivalid         (ivalid),
`ifdef IFETCH_MISALIGN_CHECK_EN
        .instr_misalign (instr_misalign),
`endif
        .iwait          (iwait)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        iresp_data_ok = 1'b0; iresp_data = '0;
        repeat (2) cyc();
        chk("rst_ivalid", ivalid, 0);
        chk("rst_pc", pc, 0);
        chk("rst_raw", raw_instr, NOP);
        chk("rst_ireq_valid", ireq_valid, 0);
        reset = 1'b0;

        // first fetch, answered on the third cycle
        cyc();
        chk("f1_ireq_valid", ireq_valid, 1);
        chk("f1_addr", ireq_addr, 64'h8000_0000);
        chk("f1_iwait", iwait, 1);
        cyc(); cyc();
        chk("f1_addr_hold", ireq_addr, 64'h8000_0000);
        iresp_data_ok = 1'b1; iresp_data = 32'h0000_0513;
        #1;
        chk("f1_iwait_ok", iwait, 0);
        chk("f1_ivalid_early", ivalid, 0);
        cyc();
        iresp_data_ok = 1'b0;
        chk("f1_ivalid", ivalid, 1);
        chk("f1_pc", pc, 64'h8000_0000);
        chk("f1_raw", raw_instr, 32'h0000_0513);
        chk("f1_no_req", ireq_valid, 0);

        // stall held for four cycles in ISSUE
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("stall_ivalid", ivalid, 1);
            chk("stall_pc", pc, 64'h8000_0000);
            chk("stall_raw", raw_instr, 32'h0000_0513);
            chk("stall_no_req", ireq_valid, 0);
        end
        stall = 1'b0;
        cyc();
        chk("post_stall_ivalid", ivalid, 0);
        chk("post_stall_req", ireq_valid, 1);
        chk("post_stall_addr", ireq_addr, 64'h8000_0004);

        // redirect while request outstanding
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
        cyc();
        redirect_valid = 1'b0;
        chk("rd1_addr_stable", ireq_addr, 64'h8000_0004);
        chk("rd1_req", ireq_valid, 1);
        iresp_data_ok = 1'b1; iresp_data = 32'hdead_beef;
        cyc();
        iresp_data_ok = 1'b0;
        chk("rd1_dropped", ivalid, 0);
        chk("rd1_new_addr", ireq_addr, 64'h8000_0100);

        // two redirects before data_ok: last one wins
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
        cyc();
        redirect_pc = 64'h8000_0300;
        cyc();
        redirect_valid = 1'b0;
        chk("rd2_addr_stable", ireq_addr, 64'h8000_0100);
        iresp_data_ok = 1'b1; iresp_data = 32'h1111_1111;
        cyc();
        iresp_data_ok = 1'b0;
        chk("rd2_dropped", ivalid, 0);
        chk("rd2_new_addr", ireq_addr, 64'h8000_0300);

        // redirect and stall together in ISSUE
        iresp_data_ok = 1'b1; iresp_data = 32'h00a0_0593;
        cyc();
        iresp_data_ok = 1'b0;
        chk("f3_ivalid", ivalid, 1);
        chk("f3_pc", pc, 64'h8000_0300);
        chk("f3_raw", raw_instr, 32'h00a0_0593);
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0400;
        cyc();
        stall = 1'b0; redirect_valid = 1'b0;
        chk("rs_ivalid", ivalid, 0);
        chk("rs_req", ireq_valid, 1);
        chk("rs_addr", ireq_addr, 64'h8000_0400);

        // redirect in the same cycle as data_ok
        iresp_data_ok = 1'b1; iresp_data = 32'h2222_2222; redirect_valid = 1'b1; redirect_pc = 64'h8000_0500;
        cyc();
        iresp_data_ok = 1'b0; redirect_valid = 1'b0;
        chk("rdok_ivalid", ivalid, 0);
        chk("rdok_addr", ireq_addr, 64'h8000_0500);

        // misaligned redirect target from ISSUE
        iresp_data_ok = 1'b1; iresp_data = 32'h0010_0073;
        cyc();
        iresp_data_ok = 1'b0;
        chk("f5_pc", pc, 64'h8000_0500);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0002;
        cyc();
        redirect_valid = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
        chk("mis_no_req", ireq_valid, 0);
        chk("mis_ivalid_low", ivalid, 0);
        cyc();
        chk("mis_ivalid", ivalid, 1);
        chk("mis_flag", instr_misalign, 1);
        chk("mis_raw", raw_instr, NOP);
        chk("mis_pc", pc, 64'h8000_0002);
        chk("mis_no_req2", ireq_valid, 0);
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc();
        redirect_valid = 1'b0;
        chk("mis_flag_clr", instr_misalign, 0);
`else
        chk("align_req", ireq_valid, 1);
        chk("align_addr", ireq_addr, 64'h8000_0000);
        iresp_data_ok = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc();
        iresp_data_ok = 1'b0; redirect_valid = 1'b0;
`endif

        // PC wraps at 64 bits
        chk("wrap_req", ireq_valid, 1);
        chk("wrap_addr0", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        iresp_data_ok = 1'b1; iresp_data = 32'h0000_0013;
        cyc();
        iresp_data_ok = 1'b0;
        chk("wrap_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_ivalid", ivalid, 1);
        cyc();
        chk("wrap_addr1", ireq_addr, 64'h0);
        chk("wrap_req1", ireq_valid, 1);

        // reset with a late data_ok in the same cycle
        reset = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h0000_1234;
        cyc();
        iresp_data_ok = 1'b0;
        chk("mrst_req", ireq_valid, 0);
        chk("mrst_ivalid", ivalid, 0);
        chk("mrst_raw", raw_instr, NOP);
        reset = 1'b0;
        cyc();
        chk("mrst_addr", ireq_addr, 64'h8000_0000);
        chk("mrst_req2", ireq_valid, 1);
        chk("mrst_ivalid2", ivalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
